// File: rtl/wb_stage_pkg.sv
// minisys_defs: constants shared by the MiniSys writeback stage
package minisys_defs;
    localparam int GPR_AW = 5;
    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LBU  = 3'd2;
    localparam logic [2:0] LOAD_LH   = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_LW   = 3'd5;
    localparam logic [GPR_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: select and sign/zero-extend the loaded byte, half or word
module load_align
    import minisys_defs::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic        is_load,
    output logic [31:0] result
);
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign shifted  = rdata >> {addr_lo, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    // decode load kind; unused encodings fall through as non-loads
    always_comb begin
        is_load = 1'b1;
        result  = '0;
        case (load_type)
            LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: result = {24'd0, byte_sel};
            LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: result = {16'd0, half_sel};
            LOAD_LW:  result = rdata;
            default:  is_load = 1'b0;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, register-file write port and HI/LO registers
module wb_stage
    import minisys_defs::*;
#(
    parameter int DW = 32,
    parameter int AW = GPR_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic [2:0]    mem_load_type,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_whilo,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);
    logic          is_load;
    logic [31:0]   load_data;
    logic [DW-1:0] next_wdata;
    logic          whilo_q;
    logic [DW-1:0] hi_pend, lo_pend, hi_reg, lo_reg;

    load_align u_align (
        .load_type (mem_load_type),
        .addr_lo   (mem_addr_lo),
        .rdata     (mem_rdata),
        .is_load   (is_load),
        .result    (load_data)
    );

    assign next_wdata = is_load ? load_data : mem_wdata;

    // MEM/WB register and HI/LO commit; reset beats flush beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            whilo_q <= 1'b0;
            hi_pend <= '0;
            lo_pend <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            if (whilo_q) begin
                hi_reg <= hi_pend;
                lo_reg <= lo_pend;
            end
            if (flush) begin
                we      <= 1'b0;
                waddr   <= '0;
                wdata   <= '0;
                whilo_q <= 1'b0;
            end else if (!stall) begin
                we      <= mem_we && (mem_waddr != REG_ZERO);
                waddr   <= mem_waddr;
                wdata   <= next_wdata;
                whilo_q <= mem_whilo;
                hi_pend <= mem_hi;
                lo_pend <= mem_lo;
            end
        end
    end

    assign hi = whilo_q ? hi_pend : hi_reg;
    assign lo = whilo_q ? lo_pend : lo_reg;
endmodule
